// File: rtl/jstepper.sv
// Bus-cycle sequencer: four-phase enable/set strobes per tick and a one-hot
// instruction step counter with a binary copy of the step.
module jstepper #(
  parameter int STEPS = 6,
  parameter int DIV   = 1,
  localparam int W    = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt,
  input  logic             step_rst,
  output logic             bus_e,
  output logic             bus_s,
  output logic [STEPS-1:0] step,
  output logic [W-1:0]     step_idx,
  output logic             tick_done,
  output logic             halted
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [W-1:0]  STEP_LAST = W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

  state_t           state_reg, state_next;
  phase_t           phase_reg, phase_next;
  logic [DW-1:0]    divcnt_reg, divcnt_next;
  logic [STEPS-1:0] step_reg, step_next;
  logic [W-1:0]     step_idx_reg, step_idx_next;
  logic             tick_done_reg, tick_done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      phase_reg     <= P0;
      divcnt_reg    <= '0;
      step_reg      <= STEPS'(1);
      step_idx_reg  <= '0;
      tick_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      divcnt_reg    <= divcnt_next;
      step_reg      <= step_next;
      step_idx_reg  <= step_idx_next;
      tick_done_reg <= tick_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    divcnt_next    = divcnt_reg;
    step_next      = step_reg;
    step_idx_next  = step_idx_reg;
    tick_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run) begin
          state_next  = RUN;
          phase_next  = P0;
          divcnt_next = '0;
        end
      end
      RUN: begin
        if (divcnt_reg == DIV_LAST) begin
          divcnt_next = '0;
          phase_next  = phase_t'(phase_reg + 2'd1);
          // Tick boundary: inputs are only honoured here, so a tick is never cut short.
          if (phase_reg == P3) begin
            tick_done_next = 1'b1;
            if (step_rst || step_idx_reg == STEP_LAST) begin
              step_next     = STEPS'(1);
              step_idx_next = '0;
            end else begin
              step_next     = {step_reg[STEPS-2:0], 1'b0};
              step_idx_next = step_idx_reg + W'(1);
            end
            if (halt) begin
              state_next = HALTED;
            end else if (!run) begin
              state_next = IDLE;
            end
          end
        end else begin
          divcnt_next = divcnt_reg + DW'(1);
        end
      end
      HALTED: begin
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode registered state only, so inputs never reach them combinationally.
  assign bus_e     = (state_reg == RUN) && (phase_reg != P3);
  assign bus_s     = (state_reg == RUN) && (phase_reg == P1);
  assign step      = step_reg;
  assign step_idx  = step_idx_reg;
  assign tick_done = tick_done_reg;
  assign halted    = (state_reg == HALTED);

endmodule
